// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed big-endian byte stream -> 32-bit word writes.
// Define IMEM_LOADER_CHKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = CHK;
    logic [7:0] xorAcc;
`else
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t state, stateNext;

    logic [15:0]       count;
    logic [ADDR_W-2:0] wordIdx;    // one bit wider than the index so MAX_WORDS itself fits
    logic [1:0]        byteIdx;
    logic [23:0]       shiftReg;
    logic              fire;
    logic [15:0]       lenNext;
    logic              lastWord;
    logic [ADDR_W-1:0] byteAddr;

    assign fire     = in_valid && in_ready;
    assign lenNext  = {count[15:8], in_byte};
    assign lastWord = (16'(wordIdx) == count - 16'd1);
    assign byteAddr = {wordIdx[ADDR_W-3:0], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: if (start) stateNext = LEN_HI;
            LEN_HI: begin
                in_ready = 1'b1;
                if (fire) stateNext = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (fire) begin
                    if (lenNext == 16'd0)                  stateNext = AFTER_DATA;
                    else if (lenNext > 16'(MAX_WORDS))     stateNext = ERR;
                    else                                   stateNext = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (fire && byteIdx == 2'd3 && lastWord) stateNext = AFTER_DATA;
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (fire) stateNext = (in_byte == xorAcc) ? DONE : ERR;
            end
`endif
            DONE, ERR: if (start) stateNext = LEN_HI;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            wordIdx  <= '0;
            byteIdx  <= '0;
            shiftReg <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            xorAcc   <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if ((state == IDLE || state == DONE || state == ERR) && start) begin
                wordIdx  <= '0;
                byteIdx  <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
                cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
                xorAcc   <= '0;
`endif
            end else begin
                case (state)
                    DONE: begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                    ERR: begin
                        error    <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                    LEN_HI: if (fire) count[15:8] <= in_byte;
                    LEN_LO: if (fire) count[7:0]  <= in_byte;
                    DATA: if (fire) begin
                        byteIdx <= byteIdx + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        xorAcc  <= xorAcc ^ in_byte;
`endif
                        if (byteIdx == 2'd3) begin
                            wr_data <= {shiftReg, in_byte};
                            wr_addr <= byteAddr;
                            wr_en   <= 1'b1;
                            wordIdx <= wordIdx + 1'b1;
                        end else begin
                            shiftReg <= {shiftReg[15:0], in_byte};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of scripted loads, hand-written corner
// sequences and randomized loads against a word-list reference model.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int MAXW   = 256;

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [7:0]        in_byte;
    logic              in_ready, wr_en, cpu_hold, done, error;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // write log captured away from the active edge
    logic [ADDR_W+31:0] wq[$];
    int                 wcyc[$];
    int                 doneCyc = -1;
    int                 pulseViol = 0;
    logic               prevDone = 1'b0, prevWr = 1'b0;
    always @(negedge clk) begin
        if (wr_en) begin
            wq.push_back({wr_addr, wr_data});
            wcyc.push_back(cyc);
            if (prevWr) pulseViol <= pulseViol + 1;
        end
        if (done && !prevDone) doneCyc <= cyc;
        prevDone <= done;
        prevWr   <= wr_en;
    end

    logic [31:0] words[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fillWords(input int n, input logic [31:0] w0, input logic [31:0] w1);
        words.delete();
        for (int i = 0; i < n; i++)
            words.push_back(i == 0 ? w0 : (i == 1 ? w1 : w0 + 32'(i)));
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            @(negedge clk); in_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk); in_valid = 1'b1; in_byte = b;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic pulseStart();
        @(negedge clk); in_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic runLoad(input logic [15:0] cnt, input int gap, input logic badChk);
        logic [7:0] x, b;
        wq.delete(); wcyc.delete();
        pulseStart();
        sendByte(cnt[15:8], gap);
        sendByte(cnt[7:0], gap);
        x = 8'h00;
        if (int'(cnt) <= MAXW) begin
            for (int i = 0; i < int'(cnt); i++)
                for (int k = 3; k >= 0; k--) begin
                    b = words[i][8*k +: 8];
                    x ^= b;
                    sendByte(b, gap);
                end
`ifdef IMEM_LOADER_CHKSUM_EN
            sendByte(badChk ? (x ^ 8'h01) : x, gap);
`else
            if (badChk) $display("note: checksum byte not used in this build");
`endif
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // expected writes: word i of the image at byte address 4*i, in order
    task automatic checkLoad(input string name, input logic expDone, input logic expErr, input int expNwr);
        int n;
        chk({name, "_nwr"}, 32'(wq.size()), 32'(expNwr));
        n = (wq.size() < expNwr) ? wq.size() : expNwr;
        for (int i = 0; i < n; i++) begin
            chk({name, "_addr"}, 32'(wq[i][ADDR_W+31:32]), 32'(i * 4));
            chk({name, "_data"}, wq[i][31:0], words[i]);
        end
        chk({name, "_done"},     32'(done),     32'(expDone));
        chk({name, "_error"},    32'(error),    32'(expErr));
        chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!expDone));
        chk({name, "_in_ready"}, 32'(in_ready), 32'h0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] cnt;
        int          gap;
        logic [31:0] w0, w1;
        logic        expDone, expErr;
        int          expNwr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [15:0] rc;
        int          rg;
        tbl[0] = '{"two_words",  16'd2,   0, 32'h24080005, 32'h00000000, 1'b1, 1'b0, 2};
        tbl[1] = '{"zero_len",   16'd0,   0, 32'h0,        32'h0,        1'b1, 1'b0, 0};
        tbl[2] = '{"too_long",   16'd257, 0, 32'h0,        32'h0,        1'b0, 1'b1, 0};
        tbl[3] = '{"after_err",  16'd1,   0, 32'hAABBCCDD, 32'h0,        1'b1, 1'b0, 1};
        tbl[4] = '{"stalled",    16'd1,   3, 32'h12345678, 32'h0,        1'b1, 1'b0, 1};
        tbl[5] = '{"full_image", 16'd256, 0, 32'h01000000, 32'h7F00FF01, 1'b1, 1'b0, 256};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_wr_en",    32'(wr_en),    32'h0);
        chk("rst_wr_addr",  32'(wr_addr),  32'h0);
        chk("rst_wr_data",  wr_data,       32'h0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'h1);
        chk("rst_done",     32'(done),     32'h0);
        chk("rst_error",    32'(error),    32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'h0);

        for (int v = 0; v < 6; v++) begin
            fillWords(int'(tbl[v].cnt) <= MAXW ? int'(tbl[v].cnt) : 0, tbl[v].w0, tbl[v].w1);
            runLoad(tbl[v].cnt, tbl[v].gap, 1'b0);
            checkLoad(tbl[v].name, tbl[v].expDone, tbl[v].expErr, tbl[v].expNwr);
            if (v == 0) begin
                if (wcyc.size() == 2) begin
                    chk("b2b_spacing", 32'(wcyc[1] - wcyc[0]), 32'd4);
`ifndef IMEM_LOADER_CHKSUM_EN
                    chk("done_latency", 32'(doneCyc), 32'(wcyc[1] + 1));
`endif
                end else begin
                    checks++; failures++;
                    $display("FAIL b2b_writes: got %0d writes expected 2", wcyc.size());
                end
            end
        end

        // reset in the middle of a 3-word load
        wq.delete(); wcyc.delete();
        fillWords(3, 32'h11223344, 32'h55667788);
        pulseStart();
        chk("ready_without_valid", 32'(in_ready), 32'h1);
        chk("hold_during_load",    32'(cpu_hold), 32'h1);
        sendByte(8'h00, 0); sendByte(8'h03, 0);
        for (int k = 3; k >= 0; k--) sendByte(words[0][8*k +: 8], 0);
        for (int k = 3; k >= 2; k--) sendByte(words[1][8*k +: 8], 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_writes",   32'(wq.size()), 32'd1);
        chk("midrst_in_ready", 32'(in_ready),  32'h0);
        chk("midrst_wr_en",    32'(wr_en),     32'h0);
        chk("midrst_wr_addr",  32'(wr_addr),   32'h0);
        chk("midrst_wr_data",  wr_data,        32'h0);
        chk("midrst_cpu_hold", 32'(cpu_hold),  32'h1);
        chk("midrst_done",     32'(done),      32'h0);
        chk("midrst_error",    32'(error),     32'h0);
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        fillWords(1, 32'hCAFEF00D, 32'h0);
        runLoad(16'd1, 0, 1'b0);
        checkLoad("post_reset", 1'b1, 1'b0, 1);

`ifdef IMEM_LOADER_CHKSUM_EN
        fillWords(1, 32'h01020408, 32'h0);
        runLoad(16'd1, 0, 1'b0);
        checkLoad("chk_good", 1'b1, 1'b0, 1);
        runLoad(16'd1, 0, 1'b1);
        checkLoad("chk_bad", 1'b0, 1'b1, 1);
`endif

        // randomized loads against the word-list model
        for (int r = 0; r < 14; r++) begin
            rc = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(257, 65535))
                                             : 16'($urandom_range(0, 6));
            rg = $urandom_range(0, 2);
            words.delete();
            if (int'(rc) <= MAXW)
                for (int i = 0; i < int'(rc); i++) words.push_back($urandom);
            runLoad(rc, rg, 1'b0);
            checkLoad("rand", int'(rc) <= MAXW, int'(rc) > MAXW, int'(rc) <= MAXW ? int'(rc) : 0);
        end

        chk("wr_en_single_cycle", 32'(pulseViol), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the pipeline fetch stage is the reader.
- Accepts a byte stream: 16-bit word-count header, then big-endian 32-bit instruction words.
- Writes each assembled word into instruction memory at byte addresses 0, 4, 8, …, matching the 10-bit PC stepping by 4.
- Holds the processor (cpu_hold) until the image is fully loaded.

Parameters:
- ADDR_W, 10, byte-address width of instruction memory (same as PC width).
- MAX_WORDS, 256, capacity in words (2^ADDR_W / 4); a larger header count is an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  producer has a byte on in_byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts in_byte this cycle.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  ADDR_W  byte address of the write, always a multiple of 4.
- wr_data  output  32  instruction word.
- cpu_hold  output  1  keeps the pipeline PC/IF stalled while high.
- done  output  1  load completed successfully.
- error  output  1  load aborted.

Behaviour:
- Reset (async): state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0; byte and word counters cleared.
- Transfer rule: a byte is consumed on a rising edge where in_valid&&in_ready. in_ready is high only in LEN_HI, LEN_LO and DATA, and is independent of in_valid.
- IDLE: start -> LEN_HI. Clear word index, byte index, done and error; assert cpu_hold.
- LEN_HI: consume byte into count[15:8] -> LEN_LO.
- LEN_LO: consume byte into count[7:0], then:
  - count==0 -> DONE.
  - count>MAX_WORDS -> ERR.
  - otherwise -> DATA.
- DATA: bytes are shifted in MSB first. Byte 0 goes to bits [31:24]; byte 3 goes to bits [7:0].
  - On the edge consuming byte 3: wr_data<=assembled word, wr_addr<=word_index*4, wr_en<=1 for exactly the next cycle. Then word_index++ and byte_index returns to 0.
  - If word_index was count-1, state -> DONE on that same edge.
- Timing: write latency is 1 cycle from the 4th-byte edge. Back-to-back words with in_valid held high give one wr_en every 4 cycles. Stalls (in_valid low) simply pause assembly.
- DONE: on the first DONE cycle's edge, done<=1 and cpu_hold<=0 (registered). They are first visible one cycle after the final wr_en cycle, or one cycle after entering DONE for count==0. They stay until start or reset.
- ERR: error<=1 and cpu_hold stays 1. No wr_en is issued and in_ready=0. Exit only via start or reset.
- start in LEN_HI, LEN_LO or DATA is ignored. start in DONE or ERR restarts as from IDLE: cpu_hold<=1, done<=0, error<=0.
- wr_addr width: word_index*4 is truncated to ADDR_W. With MAX_WORDS enforced it never wraps; the last address is 0x3FC for the defaults.
- Reset mid-load: immediate return to IDLE. Partially written memory is not cleaned; cpu_hold=1 guarantees the CPU never runs it.

Optional Feature:
IMEM_LOADER_CHKSUM_EN
- Defined:
  - After the last data byte (or after LEN_LO when count==0), the FSM enters CHK and accepts one more byte.
  - The expected value is the XOR of all data bytes; header bytes are excluded.
  - Match -> DONE. Mismatch -> ERR.
  - The final wr_en still fires normally before the compare.
- Not defined: no CHK state; DATA/LEN_LO transition straight to DONE as described above.

Test Plan:
1. Reset, start, stream 00 02 | 24 08 00 05 | 00 00 00 00 with in_valid held high -> wr_en pulses twice: addr 0x000 data 0x24080005, then addr 0x004 data 0x00000000. done=1 and cpu_hold=0 one cycle after the second pulse; in_ready=0 afterwards.
2. Header 00 00 -> no wr_en; done=1 and cpu_hold=0; error=0.
3. Header 01 01 (257 > 256) -> error=1, cpu_hold=1, in_ready=0, no wr_en. A subsequent start followed by stream 00 01 AA BB CC DD -> write 0xAABBCCDD at 0x000, done=1.
4. Header 00 01, then bytes 12 34 56 78 with in_valid low for 3 cycles between each byte -> exactly one wr_en, data 0x12345678, addr 0x000. No extra byte is consumed while in_valid=0.
5. Load of 3 words, reset asserted after the 6th data byte -> all outputs at reset values immediately. A new start plus a 1-word load completes correctly at addr 0x000.
6. (CHKSUM_EN) Stream 00 01 01 02 04 08 0F -> done=1. Same stream with final byte 0E -> error=1, cpu_hold=1; the wr_en of 0x01020408 still occurred.
